// File: rtl/timer_reload_ctrl.sv
// timer_reload_ctrl
// Control and sequencing front-end for TIMERCOUNTER_UNIT. Holds the CPU
// programmed reload, prescaler and control registers, loads the 16-bit
// reload through the unit's MSB/LSB strobes, gates counting through a
// prescaler and turns rising edges of TIMER_OV into a level interrupt with
// optional auto-reload.
module timer_reload_ctrl #(
  parameter int PRESC_W = 8  // 1..8; tick period is PRESC+1 cycles
) (
  input  logic       CLK,
  input  logic       CPU_Reset_n,
  input  logic       CFG_WR,
  input  logic [1:0] CFG_ADDR,
  input  logic [7:0] CFG_DATA,
  input  logic       IRQ_ACK,
  input  logic       TIMER_OV,
  output logic       TIMER_WR_MSB,
  output logic [7:0] TIMER_MSB,
  output logic       TIMER_WR_LSB,
  output logic [7:0] TIMER_LSB,
  output logic       TIMERCOUNTER_EN,
  output logic       TIMERCOUNTER_MODE,
  output logic       TIMER_IRQ,
  output logic [7:0] STATUS
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_MSB = 3'd1,
    S_LOAD_LSB = 3'd2,
    S_SETTLE   = 3'd3,
    S_RUN      = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [1:0] ADDR_RLD_LSB = 2'd0;
  localparam logic [1:0] ADDR_RLD_MSB = 2'd1;
  localparam logic [1:0] ADDR_CTRL    = 2'd2;
  localparam logic [1:0] ADDR_PRESC   = 2'd3;

  // Control register bit positions
  localparam int CTRL_START  = 0;
  localparam int CTRL_MODE   = 1;
  localparam int CTRL_AUTO   = 2;
  localparam int CTRL_IRQ_EN = 3;

  logic [15:0]        reload_q;
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_cnt;
  logic               mode_q;
  logic               auto_q;
  logic               irq_en_q;

  state_t             state;
  state_t             state_nxt;

  logic               ov_q;
  logic               irq_pend;
  logic               overrun;

  logic               ctrl_wr;
  logic               in_run;
  logic               tick;
  logic               ov_event;
  logic               busy;

  // A control write always redirects the sequencer: START=1 (re)starts a
  // load sequence from any state, START=0 parks it in IDLE.
  assign ctrl_wr  = CFG_WR && (CFG_ADDR == ADDR_CTRL);

  assign in_run   = (state == S_RUN);

  // The >= compare (rather than ==) still produces a tick when the
  // prescaler is lowered below the running count.
  assign tick     = in_run && (presc_cnt >= presc_q);

  // ov_q holds the previous TIMER_OV; SETTLE gives it one cycle to pick up
  // the freshly loaded counter's flag so a reload of 0 is not an event.
  assign ov_event = in_run && TIMER_OV && !ov_q;

  assign busy     = (state != S_IDLE) && (state != S_DONE);

  // CPU-visible configuration registers
  always_ff @(posedge CLK or negedge CPU_Reset_n) begin
    if (!CPU_Reset_n) begin
      reload_q <= '0;
      presc_q  <= '0;
      mode_q   <= 1'b0;
      auto_q   <= 1'b0;
      irq_en_q <= 1'b0;
    end else if (CFG_WR) begin
      unique case (CFG_ADDR)
        ADDR_RLD_LSB: reload_q[7:0]  <= CFG_DATA;
        ADDR_RLD_MSB: reload_q[15:8] <= CFG_DATA;
        ADDR_CTRL: begin
          mode_q   <= CFG_DATA[CTRL_MODE];
          auto_q   <= CFG_DATA[CTRL_AUTO];
          irq_en_q <= CFG_DATA[CTRL_IRQ_EN];
        end
        ADDR_PRESC:   presc_q <= CFG_DATA[PRESC_W-1:0];
      endcase
    end
  end

  // Sequencer state register
  always_ff @(posedge CLK or negedge CPU_Reset_n) begin
    if (!CPU_Reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; strobes and enable are pure functions of the state so
  // they drop as soon as reset forces the state register back to IDLE.
  always_comb begin
    state_nxt       = state;
    TIMER_WR_MSB    = 1'b0;
    TIMER_WR_LSB    = 1'b0;
    TIMERCOUNTER_EN = 1'b0;

    case (state)
      S_LOAD_MSB: begin
        TIMER_WR_MSB = 1'b1;
        state_nxt    = S_LOAD_LSB;
      end
      S_LOAD_LSB: begin
        TIMER_WR_LSB = 1'b1;
        state_nxt    = S_SETTLE;
      end
      S_SETTLE: begin
        state_nxt = S_RUN;
      end
      S_RUN: begin
        TIMERCOUNTER_EN = tick;
        if (ov_event) begin
          state_nxt = auto_q ? S_LOAD_MSB : S_DONE;
        end
      end
      default: begin
        state_nxt = state;
      end
    endcase

    if (ctrl_wr) begin
      state_nxt = CFG_DATA[CTRL_START] ? S_LOAD_MSB : S_IDLE;
    end
  end

  // Prescaler: free-runs only in RUN, restarting on every tick
  always_ff @(posedge CLK or negedge CPU_Reset_n) begin
    if (!CPU_Reset_n) begin
      presc_cnt <= '0;
    end else if (!in_run || tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end

  // Overflow edge baseline, tracking TIMER_OV every cycle
  always_ff @(posedge CLK or negedge CPU_Reset_n) begin
    if (!CPU_Reset_n) begin
      ov_q <= 1'b0;
    end else begin
      ov_q <= TIMER_OV;
    end
  end

  // Pending interrupt and sticky overrun; a new event beats IRQ_ACK
  always_ff @(posedge CLK or negedge CPU_Reset_n) begin
    if (!CPU_Reset_n) begin
      irq_pend <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (ov_event && irq_en_q) begin
        irq_pend <= 1'b1;
      end else if (IRQ_ACK) begin
        irq_pend <= 1'b0;
      end

      if (ov_event && irq_pend) begin
        overrun <= 1'b1;
      end else if (IRQ_ACK) begin
        overrun <= 1'b0;
      end
    end
  end

  assign TIMER_MSB         = reload_q[15:8];
  assign TIMER_LSB         = reload_q[7:0];
  assign TIMERCOUNTER_MODE = mode_q;
  assign TIMER_IRQ         = irq_pend;
  assign STATUS            = {2'b00, overrun, auto_q, mode_q, irq_pend,
                              (state == S_DONE), busy};

endmodule

// File: tb/tb_timer_reload_ctrl.sv
// Testbench for timer_reload_ctrl: directed scenarios followed by random
// register/ack traffic, with a behavioural TIMERCOUNTER_UNIT and a
// cycle-level reference model of the controller.
module tb_timer_reload_ctrl;

  logic       CLK = 1'b0;
  logic       CPU_Reset_n;
  logic       CFG_WR;
  logic [1:0] CFG_ADDR;
  logic [7:0] CFG_DATA;
  logic       IRQ_ACK;
  logic       TIMER_OV;
  logic       TIMER_WR_MSB;
  logic [7:0] TIMER_MSB;
  logic       TIMER_WR_LSB;
  logic [7:0] TIMER_LSB;
  logic       TIMERCOUNTER_EN;
  logic       TIMERCOUNTER_MODE;
  logic       TIMER_IRQ;
  logic [7:0] STATUS;

  always #5 CLK = ~CLK;

  timer_reload_ctrl #(.PRESC_W(8)) dut (
    .CLK              (CLK),
    .CPU_Reset_n      (CPU_Reset_n),
    .CFG_WR           (CFG_WR),
    .CFG_ADDR         (CFG_ADDR),
    .CFG_DATA         (CFG_DATA),
    .IRQ_ACK          (IRQ_ACK),
    .TIMER_OV         (TIMER_OV),
    .TIMER_WR_MSB     (TIMER_WR_MSB),
    .TIMER_MSB        (TIMER_MSB),
    .TIMER_WR_LSB     (TIMER_WR_LSB),
    .TIMER_LSB        (TIMER_LSB),
    .TIMERCOUNTER_EN  (TIMERCOUNTER_EN),
    .TIMERCOUNTER_MODE(TIMERCOUNTER_MODE),
    .TIMER_IRQ        (TIMER_IRQ),
    .STATUS           (STATUS)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural timer unit: 16-bit counter, OV flag while the count is zero
  logic [15:0] t_cnt;
  assign TIMER_OV = (t_cnt == 16'h0000);

  // Reference model of the controller
  logic [15:0] m_reload;
  int          m_presc;
  bit          m_mode, m_auto, m_irqen;
  bit          m_active;   // inside a load/run sequence
  int          m_pos;      // cycles into the sequence: 1 MSB, 2 LSB, 3 settle, >=4 run
  bit          m_done;
  int          m_wait;     // run cycles since the last tick
  bit          m_ovq, m_pend, m_ovr;

  // Per-cycle logs for the directed scenarios
  int          cyc_no;
  logic [31:0] en_mask, msb_mask, lsb_mask, irq_mask, done_mask, busy_mask, ovr_mask;
  logic [7:0]  msb_val, lsb_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_reload = '0; m_presc = 0; m_mode = 0; m_auto = 0; m_irqen = 0;
    m_active = 0; m_pos = 0; m_done = 0; m_wait = 0;
    m_ovq = 0; m_pend = 0; m_ovr = 0;
    t_cnt = '0;
  endtask

  task automatic clr_log();
    cyc_no = 0;
    en_mask = '0; msb_mask = '0; lsb_mask = '0; irq_mask = '0;
    done_mask = '0; busy_mask = '0; ovr_mask = '0;
    msb_val = '0; lsb_val = '0;
  endtask

  // One clock cycle: check outputs against the model, advance model and
  // timer unit across the edge, then release single-cycle inputs.
  task automatic step();
    logic        e_msb, e_lsb, e_run, e_en, ov_now, ev;
    logic [15:0] t_next;
    bit          n_active, n_done, n_pend, n_ovr;
    int          n_pos, n_wait;
    logic        wr;
    logic [1:0]  addr;
    logic [7:0]  data;
    #1;
    ov_now = (t_cnt == 16'h0000);
    e_msb  = m_active && (m_pos == 1);
    e_lsb  = m_active && (m_pos == 2);
    e_run  = m_active && (m_pos >= 4);
    e_en   = e_run && (m_wait >= m_presc);
    chk("outputs", {27'd0, TIMER_WR_MSB, TIMER_WR_LSB, TIMERCOUNTER_EN, TIMERCOUNTER_MODE, TIMER_IRQ},
                   {27'd0, e_msb, e_lsb, e_en, m_mode, m_pend});
    chk("reload_out", {16'd0, TIMER_MSB, TIMER_LSB}, {16'd0, m_reload});
    chk("status", {24'd0, STATUS}, {24'd0, 2'b00, m_ovr, m_auto, m_mode, m_pend, m_done, m_active});

    if (cyc_no < 32) begin
      en_mask[cyc_no[4:0]]   = TIMERCOUNTER_EN;
      msb_mask[cyc_no[4:0]]  = TIMER_WR_MSB;
      lsb_mask[cyc_no[4:0]]  = TIMER_WR_LSB;
      irq_mask[cyc_no[4:0]]  = TIMER_IRQ;
      done_mask[cyc_no[4:0]] = STATUS[1];
      busy_mask[cyc_no[4:0]] = STATUS[0];
      ovr_mask[cyc_no[4:0]]  = STATUS[5];
    end
    if (TIMER_WR_MSB) msb_val = TIMER_MSB;
    if (TIMER_WR_LSB) lsb_val = TIMER_LSB;

    ev     = e_run && ov_now && !m_ovq;
    n_pend = (ev && m_irqen) ? 1'b1 : (IRQ_ACK ? 1'b0 : m_pend);
    n_ovr  = (ev && m_pend)  ? 1'b1 : (IRQ_ACK ? 1'b0 : m_ovr);
    n_active = m_active; n_done = m_done; n_pos = m_pos;
    if (ev) begin
      if (m_auto) n_pos = 1;
      else begin n_active = 0; n_done = 1; n_pos = 0; end
    end else if (m_active && m_pos < 4) begin
      n_pos = m_pos + 1;
    end
    wr = CFG_WR; addr = CFG_ADDR; data = CFG_DATA;
    if (wr && addr == 2'd2) begin
      n_active = data[0]; n_done = 0; n_pos = data[0] ? 1 : 0;
    end
    n_wait = e_run ? (e_en ? 0 : m_wait + 1) : 0;

    t_next = t_cnt;
    if (TIMER_WR_MSB) t_next[15:8] = TIMER_MSB;
    if (TIMER_WR_LSB) t_next[7:0]  = TIMER_LSB;
    if (TIMERCOUNTER_EN) t_next = TIMERCOUNTER_MODE ? t_cnt + 16'd1 : t_cnt - 16'd1;

    @(posedge CLK);
    #1;
    t_cnt = t_next;
    m_ovq = ov_now; m_pend = n_pend; m_ovr = n_ovr;
    m_active = n_active; m_done = n_done; m_pos = n_pos; m_wait = n_wait;
    if (wr) begin
      case (addr)
        2'd0: m_reload[7:0]  = data;
        2'd1: m_reload[15:8] = data;
        2'd2: begin m_mode = data[1]; m_auto = data[2]; m_irqen = data[3]; end
        default: m_presc = int'(data);
      endcase
    end
    CFG_WR = 1'b0; IRQ_ACK = 1'b0;
    cyc_no++;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    CFG_WR = 1'b1; CFG_ADDR = a; CFG_DATA = d;
    step();
  endtask

  task automatic ack();
    IRQ_ACK = 1'b1;
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {27'd0, TIMER_WR_MSB, TIMER_WR_LSB, TIMERCOUNTER_EN, TIMERCOUNTER_MODE, TIMER_IRQ}, 32'd0);
    chk({tag, "_reload"}, {16'd0, TIMER_MSB, TIMER_LSB}, 32'd0);
    chk({tag, "_status"}, {24'd0, STATUS}, 32'd0);
  endtask

  initial begin
    CPU_Reset_n = 1'b1;
    CFG_WR = 1'b0; CFG_ADDR = 2'd0; CFG_DATA = 8'd0; IRQ_ACK = 1'b0;
    model_reset();
    clr_log();
    #3 CPU_Reset_n = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk_all_zero("reset");
    CPU_Reset_n = 1'b1;

    // Down mode, reload 3, PRESC 0, IRQ_EN, no auto
    wr_reg(2'd0, 8'h03); wr_reg(2'd1, 8'h00); wr_reg(2'd3, 8'h00);
    clr_log();
    wr_reg(2'd2, 8'h09);
    repeat (12) step();
    chk("t1_wr_msb_cycles", msb_mask & 32'h1FFF, 32'h0002);
    chk("t1_wr_lsb_cycles", lsb_mask & 32'h1FFF, 32'h0004);
    chk("t1_msb_val", {24'd0, msb_val}, 32'h00);
    chk("t1_lsb_val", {24'd0, lsb_val}, 32'h03);
    chk("t1_en_cycles", en_mask & 32'h1F7F, 32'h0070);
    chk("t1_irq_cycles", irq_mask & 32'h1FFF, 32'h1F00);
    chk("t1_done_cycles", done_mask & 32'h1FFF, 32'h1F00);
    chk("t1_busy_cycles", busy_mask & 32'h1FFF, 32'h00FE);

    // Same with PRESC 2: tick every third run cycle
    ack();
    wr_reg(2'd3, 8'h02);
    clr_log();
    wr_reg(2'd2, 8'h09);
    repeat (15) step();
    chk("t2_en_cycles", en_mask & 32'hFFFF, 32'h1240);
    chk("t2_irq_cycles", irq_mask & 32'hFFFF, 32'hC000);

    // Auto-reload, reload 2, events every 6 cycles at 6, 12, 18
    ack();
    wr_reg(2'd0, 8'h02); wr_reg(2'd1, 8'h00); wr_reg(2'd3, 8'h00);
    clr_log();
    wr_reg(2'd2, 8'h0D);
    repeat (14) step();
    ack();                     // cycle 15
    repeat (2) step();
    ack();                     // cycle 18, same cycle as an event
    repeat (3) step();
    wr_reg(2'd2, 8'h0C);       // cycle 22, START=0 while running
    repeat (2) step();
    chk("t3_wr_msb_cycles", msb_mask & 32'h007F_FFFF, 32'h0008_2082);
    chk("t3_wr_lsb_cycles", lsb_mask & 32'h007F_FFFF, 32'h0010_4104);
    chk("t3_irq_cycles", irq_mask & 32'h007F_FFFF, 32'h0078_FF80);
    chk("t3_overrun_cycles", ovr_mask & 32'h007F_FFFF, 32'h0000_E000);
    chk("t5_stop_en", (en_mask >> 22) & 32'h7, 32'h1);
    chk("t5_stop_busy", (busy_mask >> 22) & 32'h7, 32'h1);
    chk("t5_stop_done", (done_mask >> 23) & 32'h3, 32'h0);

    // Restart mid-run picks up the current reload
    wr_reg(2'd0, 8'h55); wr_reg(2'd1, 8'h12);
    clr_log();
    wr_reg(2'd2, 8'h09);
    repeat (6) step();
    wr_reg(2'd0, 8'h34);       // cycle 7
    wr_reg(2'd2, 8'h09);       // cycle 8
    repeat (3) step();
    chk("t5_restart_msb_cycles", msb_mask & 32'h0FFF, 32'h0202);
    chk("t5_restart_lsb_cycles", lsb_mask & 32'h0FFF, 32'h0404);
    chk("t5_restart_en", (en_mask >> 4) & 32'h3F, 32'h1F);
    chk("t5_restart_msb_val", {24'd0, msb_val}, 32'h12);
    chk("t5_restart_lsb_val", {24'd0, lsb_val}, 32'h34);
    wr_reg(2'd2, 8'h08);
    ack();

    // Up mode, reload 0xFFFE: two ticks to the overflow
    wr_reg(2'd0, 8'hFE); wr_reg(2'd1, 8'hFF); wr_reg(2'd3, 8'h00);
    clr_log();
    wr_reg(2'd2, 8'h0B);
    repeat (9) step();
    chk("t6_en_cycles", en_mask & 32'h3F, 32'h30);
    chk("t6_irq_cycles", irq_mask & 32'h3FF, 32'h380);
    chk("t6_done_cycles", done_mask & 32'h3FF, 32'h380);

    // Reset asserted during LOAD_LSB
    clr_log();
    wr_reg(2'd2, 8'h0B);
    step();
    #1;
    chk("rst_pre_wr_lsb", {31'd0, TIMER_WR_LSB}, 32'd1);
    CPU_Reset_n = 1'b0;
    #1;
    chk_all_zero("rst_async");
    @(posedge CLK);
    #1;
    chk_all_zero("rst_hold");
    CPU_Reset_n = 1'b1;
    model_reset();

    // Random register traffic and acknowledges
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 8) begin
        CFG_WR   = 1'b1;
        CFG_ADDR = 2'($urandom_range(0, 3));
        case (CFG_ADDR)
          2'd0:    CFG_DATA = 8'($urandom_range(0, 6));
          2'd1:    CFG_DATA = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'h00;
          2'd2:    CFG_DATA = {4'd0, 3'($urandom_range(0, 7)), ($urandom_range(0, 4) != 0)};
          default: CFG_DATA = 8'($urandom_range(0, 3));
        endcase
      end
      IRQ_ACK = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
